// File: rtl/mod_rx_frame_pkg.sv
// mod_rx_frame_pkg: frame state encodings, default sync byte and FIFO entry layout.
package mod_rx_frame_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CHK} state_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;
endpackage

// File: rtl/mod_rx_frame_if.sv
// mod_rx_frame_if: stream input plus valid/ready payload output of the frame receiver.
interface mod_rx_frame_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       i_ready;
    modport slave (input i_valid, i_data, i_ready, output o_valid, o_data, o_last);
    modport master(output i_valid, i_data, i_ready, input o_valid, o_data, o_last);
endinterface

// File: rtl/mod_rx_fifo.sv
// mod_rx_fifo: first-word-fall-through FIFO of {last,data} entries with extra-MSB pointers.
module mod_rx_fifo
    import mod_rx_frame_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst_x,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    entry_t      mem [DEPTH];
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = wptr == rptr;
    assign pop_data = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mod_rx_frame.sv
// mod_rx_frame: deframes SYNC/LEN/PAYLOAD/CHK, buffers payload, pulses per-frame status.
// Define MOD_RX_STAT_EN to enable the saturating o_err_cnt counter.
module mod_rx_frame
    import mod_rx_frame_pkg::*;
#(
    parameter int         P_DEPTH = 16,
    parameter logic [7:0] P_SYNC  = SYNC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_x,
    mod_rx_frame_if.slave  bus,
    output logic           o_frame_ok,
    output logic           o_frame_err,
    output logic [7:0]     o_err_cnt
);
    state_t     state, next_state;
    logic [7:0] cnt, sum;
    logic       ovf, full, empty, push, pop, chk_ok;
    entry_t     push_entry, pop_entry;
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) state <= ST_IDLE;
        else        state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (bus.i_valid) begin
            case (state)
                ST_IDLE: next_state = (bus.i_data == P_SYNC) ? ST_LEN : ST_IDLE;
                ST_LEN:  next_state = (bus.i_data == 8'd0) ? ST_CHK : ST_DATA;
                ST_DATA: next_state = (cnt == 8'd1) ? ST_CHK : ST_DATA;
                default: next_state = ST_IDLE;
            endcase
        end
    end
    always_comb begin
        push       = bus.i_valid && state == ST_DATA && !full;
        push_entry = '{last: cnt == 8'd1, data: bus.i_data};
        chk_ok     = (bus.i_data == sum) && !ovf;
    end
    // Full FIFO drops the byte but the frame keeps counting; ovf forces an error at CHK.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cnt         <= '0;
            sum         <= '0;
            ovf         <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            if (bus.i_valid) begin
                case (state)
                    ST_LEN: begin
                        cnt <= bus.i_data;
                        sum <= bus.i_data;
                    end
                    ST_DATA: begin
                        sum <= sum + bus.i_data;
                        cnt <= cnt - 8'd1;
                        if (full) ovf <= 1'b1;
                    end
                    ST_CHK: begin
                        o_frame_ok  <= chk_ok;
                        o_frame_err <= !chk_ok;
                        ovf         <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign pop         = bus.o_valid && bus.i_ready;
    assign bus.o_valid = !empty;
    assign bus.o_data  = pop_entry.data;
    assign bus.o_last  = pop_entry.last;
    mod_rx_fifo #(.DEPTH(P_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_x     (rst_x),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (full),
        .empty     (empty)
    );
`ifdef MOD_RX_STAT_EN
    logic [7:0] err_cnt;
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)                              err_cnt <= '0;
        else if (o_frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
    assign o_err_cnt = err_cnt;
`else
    assign o_err_cnt = 8'h00;
`endif
endmodule
